serial_eq_accumulator: RTL and testbench
========================================

// Module: serial_eq_accumulator
// PURPOSE
//  Bit-serial word comparator. Sits directly downstream of the 1-bit equality stage and consumes one bit pair per accepted beat.
//  Accumulates WIDTH beats into a word-level equality flag and a mismatch (Hamming) count, then pulses done.
//  Used wherever operands arrive serially and a full parallel comparator is not wanted.
// PARAMETERS
//  WIDTH  8                   bits per compared word (>=2)
//  CW     $clog2(WIDTH+1)     localparam; width of beat counter and diff_cnt
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      begin a new word compare (sampled only in IDLE or DONE)
//  abort     in   1      synchronous cancel of the word in progress
//  bit_valid in   1      bit_a/bit_b valid this cycle (sampled only in SHIFT)
//  bit_a     in   1      operand A bit, MSB first
//  bit_b     in   1      operand B bit, MSB first
//  busy      out  1      high while in SHIFT
//  done      out  1      one-cycle pulse; result outputs updated on the same edge
//  eq        out  1      1 = all WIDTH bit pairs were equal
//  diff_cnt  out  CW     number of unequal bit pairs in the last word
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; busy=0, done=0, eq=0, diff_cnt=0 (gt=0, lt=0). Applies mid-word; partial word discarded.
//  FSM: IDLE, SHIFT, DONE (registered state, registered outputs).
//   IDLE : start=1 -> SHIFT; internal acc_eq=1, acc_diff=0, beat_cnt=0. bit_valid ignored.
//   SHIFT: busy=1. Each cycle with bit_valid=1: acc_eq &= (bit_a==bit_b); acc_diff += (bit_a!=bit_b); beat_cnt++.
//          bit_valid=0 -> hold; no timeout, gaps of any length allowed.
//          Beat with beat_cnt==WIDTH-1 -> DONE; on that edge eq<=final acc_eq, diff_cnt<=final acc_diff.
//   DONE : done=1 for exactly one cycle. start=1 -> SHIFT (back-to-back, accumulators cleared); else -> IDLE.
//  Latency: done high in the cycle after the edge that accepts beat WIDTH-1.
//  eq/diff_cnt/gt/lt hold their value until the next completed word; never change during SHIFT.
//  start in SHIFT ignored (no restart). start with bit_valid in the IDLE cycle: bit not taken.
//  abort=1 in SHIFT -> IDLE next edge, no done, result outputs unchanged. abort outranks start and bit_valid. abort in IDLE/DONE: no effect except DONE+start+abort -> IDLE.
//  diff_cnt max = WIDTH; CW sized so it never wraps. beat_cnt cleared on every entry to SHIFT.
// CONFIGURATION
//  SERIAL_CMP_MAG_EN defined: extra ports gt (out,1) and lt (out,1), reset 0.
//   Internal decided flag: first unequal beat (MSB first) sets acc_gt=bit_a&~bit_b, acc_lt=~bit_a&bit_b; later beats do not change them.
//   gt/lt registered on the DONE-entry edge with eq; exactly one of eq/gt/lt is 1 after a word.
//  SERIAL_CMP_MAG_EN undefined: gt/lt ports and magnitude logic absent; all else identical.
// TESTING  (WIDTH=8, one beat per cycle unless stated)
//  1 rst_n=0 after 4 beats of a word -> busy=0, done=0, eq=0, diff_cnt=0 immediately; no done later.
//  2 start, A=0xA5 B=0xA5 -> done 1 cycle after 8th beat; eq=1, diff_cnt=0 (gt=0, lt=0).
//  3 A=0xA5 B=0x5A -> eq=0, diff_cnt=8; MAG: gt=1, lt=0.
//  4 A=0x80 B=0x81, bit_valid low 3 cycles after beat 2 -> done delayed 3 cycles; eq=0, diff_cnt=1; MAG: lt=1.
//  5 abort after beat 4 of A=0xFF B=0x00 -> IDLE, no done, eq/diff_cnt keep previous word; next start completes normally.
//  6 start held high throughout two words -> ignored in SHIFT; taken in DONE cycle; second done exactly 9 cycles after first.

Source files
------------

// File: rtl/serial_eq_accumulator.sv
//-----------------------------------------------------------------------------
// serial_eq_accumulator
//
// Bit-serial word comparator. It consumes one (bit_a, bit_b) pair per accepted
// beat, MSB first. After WIDTH beats it produces:
//   - a word-level equality flag
//   - a mismatch (Hamming) count
// and it pulses done for one cycle.
//
// Optional feature macro: SERIAL_CMP_MAG_EN
//   When defined, the block adds gt/lt magnitude outputs. The first unequal
//   bit pair (MSB first) decides the magnitude relation.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    begin a word compare (honoured in IDLE or DONE)
//   abort      in   1    synchronous cancel of the word in progress
//   bit_valid  in   1    bit_a/bit_b carry a beat this cycle (SHIFT only)
//   bit_a      in   1    operand A bit, MSB first
//   bit_b      in   1    operand B bit, MSB first
//   busy       out  1    high while a word is being shifted in
//   done       out  1    one-cycle pulse; results update on the same edge
//   eq         out  1    1 when every bit pair of the last word matched
//   diff_cnt   out  CW   number of unequal bit pairs in the last word
//   gt         out  1    (SERIAL_CMP_MAG_EN) last word had A > B
//   lt         out  1    (SERIAL_CMP_MAG_EN) last word had A < B
//-----------------------------------------------------------------------------
module serial_eq_accumulator #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          bit_valid,
    input  logic          bit_a,
    input  logic          bit_b,
    output logic          busy,
    output logic          done,
    output logic          eq,
`ifdef SERIAL_CMP_MAG_EN
    output logic [CW-1:0] diff_cnt,
    output logic          gt,
    output logic          lt
`else
    output logic [CW-1:0] diff_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    // Per-word accumulators. They carry no reset: every entry to SHIFT
    // clears them, and results are only loaded from a word that was started.
    logic          r_acc_eq;
    logic [CW-1:0] r_acc_diff;
    logic [CW-1:0] r_beat_cnt;

    // Result registers, visible on the outputs.
    logic          r_eq;
    logic [CW-1:0] r_diff_cnt;

    logic          w_start_shift;
    logic          w_beat;
    logic          w_last_beat;
    logic          w_bit_ne;
    logic          w_acc_eq_next;
    logic [CW-1:0] w_acc_diff_next;

    // abort has no effect in IDLE, but in DONE it suppresses a back-to-back start.
    assign w_start_shift = ((r_state == S_IDLE) && start) ||
                           ((r_state == S_DONE) && start && !abort);
    assign w_beat        = (r_state == S_SHIFT) && bit_valid && !abort;
    assign w_last_beat   = w_beat && (r_beat_cnt == CW'(WIDTH - 1));

    assign w_bit_ne        = bit_a ^ bit_b;
    assign w_acc_eq_next   = r_acc_eq & ~w_bit_ne;
    assign w_acc_diff_next = r_acc_diff + {{(CW-1){1'b0}}, w_bit_ne};

    //--------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_last_beat) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start && !abort) begin
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------
    // FSM: outputs, decoded from the registered state
    //--------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_SHIFT: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------
    // Word accumulators and beat counter
    //--------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_start_shift) begin
            r_acc_eq   <= 1'b1;
            r_acc_diff <= '0;
            r_beat_cnt <= '0;
        end else if (w_beat) begin
            r_acc_eq   <= w_acc_eq_next;
            r_acc_diff <= w_acc_diff_next;
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    //--------------------------------------------------------------------
    // Result registers: loaded only on the edge that accepts the last beat,
    // so they stay stable during SHIFT and across aborted words.
    //--------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eq       <= 1'b0;
            r_diff_cnt <= '0;
        end else if (w_last_beat) begin
            r_eq       <= w_acc_eq_next;
            r_diff_cnt <= w_acc_diff_next;
        end
    end

    assign eq       = r_eq;
    assign diff_cnt = r_diff_cnt;

`ifdef SERIAL_CMP_MAG_EN
    logic r_decided;
    logic r_acc_gt;
    logic r_acc_lt;
    logic r_gt;
    logic r_lt;
    logic w_first_ne;
    logic w_acc_gt_next;
    logic w_acc_lt_next;

    // Only the most significant unequal pair decides the magnitude relation.
    assign w_first_ne    = w_bit_ne & ~r_decided;
    assign w_acc_gt_next = w_first_ne ? (bit_a & ~bit_b) : r_acc_gt;
    assign w_acc_lt_next = w_first_ne ? (~bit_a & bit_b) : r_acc_lt;

    always_ff @(posedge clk) begin
        if (w_start_shift) begin
            r_decided <= 1'b0;
            r_acc_gt  <= 1'b0;
            r_acc_lt  <= 1'b0;
        end else if (w_beat) begin
            r_decided <= r_decided | w_bit_ne;
            r_acc_gt  <= w_acc_gt_next;
            r_acc_lt  <= w_acc_lt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gt <= 1'b0;
            r_lt <= 1'b0;
        end else if (w_last_beat) begin
            r_gt <= w_acc_gt_next;
            r_lt <= w_acc_lt_next;
        end
    end

    assign gt = r_gt;
    assign lt = r_lt;
`endif

endmodule

// File: tb/tb_serial_eq_accumulator.sv
module tb_serial_eq_accumulator;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          bit_valid;
    logic          bit_a;
    logic          bit_b;
    logic          busy;
    logic          done;
    logic          eq;
    logic [CW-1:0] diff_cnt;
`ifdef SERIAL_CMP_MAG_EN
    logic          gt;
    logic          lt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Expected result outputs (reference model state for the held results).
    logic          exp_eq;
    logic [CW-1:0] exp_diff;
    logic          exp_gt;
    logic          exp_lt;

    serial_eq_accumulator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .bit_valid (bit_valid),
        .bit_a     (bit_a),
        .bit_b     (bit_b),
        .busy      (busy),
        .done      (done),
        .eq        (eq),
`ifdef SERIAL_CMP_MAG_EN
        .diff_cnt  (diff_cnt),
        .gt        (gt),
        .lt        (lt)
`else
        .diff_cnt  (diff_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_results(input string tag);
        check({tag, ".eq"},   {31'd0, eq}, {31'd0, exp_eq});
        check({tag, ".diff"}, 32'(diff_cnt), 32'(exp_diff));
`ifdef SERIAL_CMP_MAG_EN
        check({tag, ".gt"},   {31'd0, gt}, {31'd0, exp_gt});
        check({tag, ".lt"},   {31'd0, lt}, {31'd0, exp_lt});
`endif
    endtask

    // Runs one word: the start cycle (with a junk beat that must be ignored),
    // then W beats MSB first, with an optional stall after 'gap_after' beats.
    // Returns the cycle index at which done was observed high.
    task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int gap_after, input int gap_len,
                            input bit keep_start, output int done_cyc);
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_a     = 1'($urandom);
        bit_b     = 1'($urandom);
        tick();
        check("start.busy", {31'd0, busy}, 32'd1);
        check("start.done", {31'd0, done}, 32'd0);
        if (!keep_start) start = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            bit_valid = 1'b1;
            bit_a     = a[i];
            bit_b     = b[i];
            tick();
            if (i != 0) begin
                check("beat.done", {31'd0, done}, 32'd0);
                check_results("beat.hold");
                if ((W - i) == gap_after && gap_len > 0) begin
                    bit_valid = 1'b0;
                    bit_a     = 1'($urandom);
                    bit_b     = 1'($urandom);
                    for (int g = 0; g < gap_len; g++) begin
                        tick();
                        check("gap.busy", {31'd0, busy}, 32'd1);
                        check("gap.done", {31'd0, done}, 32'd0);
                    end
                end
            end
        end
        bit_valid = 1'b0;
        // The model: word-level results straight from the operand values.
        exp_eq   = (a == b);
        exp_diff = CW'($countones(a ^ b));
        exp_gt   = (a > b);
        exp_lt   = (a < b);
        check("word.done", {31'd0, done}, 32'd1);
        check("word.busy", {31'd0, busy}, 32'd0);
        check_results("word");
        done_cyc = cyc;
    endtask

    task automatic idle_after_done(input string tag);
        start     = 1'b0;
        bit_valid = 1'b0;
        tick();
        check({tag, ".done_low"}, {31'd0, done}, 32'd0);
        check({tag, ".busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int d1, d2, cs;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        bit_valid = 1'b0; bit_a = 1'b0; bit_b = 1'b0;
        exp_eq = 1'b0; exp_diff = '0; exp_gt = 1'b0; exp_lt = 1'b0;
        tick();
        tick();
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check_results("rst");
        rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a word.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            bit_a = 1'($urandom);
            bit_b = 1'($urandom);
            tick();
        end
        check("midrst.busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.busy", {31'd0, busy}, 32'd0);
        check("midrst.done", {31'd0, done}, 32'd0);
        check_results("midrst");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bit_valid = 1'b1;
            bit_a = 1'($urandom);
            bit_b = 1'($urandom);
            tick();
            check("midrst.no_done", {31'd0, done}, 32'd0);
            check("midrst.idle", {31'd0, busy}, 32'd0);
        end
        bit_valid = 1'b0;

        // Equal words.
        run_word(8'hA5, 8'hA5, 0, 0, 1'b0, d1);
        idle_after_done("eqword");

        // All bits differ.
        run_word(8'hA5, 8'h5A, 0, 0, 1'b0, d1);
        idle_after_done("alldiff");

        // Stall of 3 cycles after beat 2 delays done by 3 cycles.
        start = 1'b1;
        cs = cyc + 1;
        run_word(8'h80, 8'h81, 2, 3, 1'b0, d1);
        check("stall.latency", 32'(d1 - cs), 32'(W + 3));
        idle_after_done("stall");

        // Abort after 4 beats: no done, results keep the previous word.
        start = 1'b1;
        bit_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; bit_a = 1'b1; bit_b = 1'b0;
            tick();
        end
        abort = 1'b1; start = 1'b1; bit_valid = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0; bit_valid = 1'b0;
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.done", {31'd0, done}, 32'd0);
        check_results("abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort.no_done", {31'd0, done}, 32'd0);
        end
        run_word(8'h3C, 8'h3C, 0, 0, 1'b0, d1);
        idle_after_done("postabort");

        // start held high: ignored in SHIFT, taken in the DONE cycle.
        run_word(8'h12, 8'h13, 0, 0, 1'b1, d1);
        run_word(8'hF0, 8'h0F, 0, 0, 1'b1, d2);
        check("b2b.spacing", 32'(d2 - d1), 32'(W + 1));
        // DONE + start + abort goes to IDLE.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("doneabort.busy", {31'd0, busy}, 32'd0);
        check("doneabort.done", {31'd0, done}, 32'd0);

        // Randomised words with random stalls.
        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            run_word(ra, rb, $urandom_range(1, W - 1), $urandom_range(0, 3), 1'b0, d1);
            idle_after_done("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
